// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - writeback, CSR and redirect bundle for trap_ctrl (irq pins with TRAP_CTRL_IRQ_EN)
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            wb_valid_i;
    logic [XLEN-1:0] wb_pc_i;
    logic            exc_ecall_i;
    logic            exc_illegal_i;
    logic            exc_mret_i;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;
    logic            redirect_ready_i;
`ifdef TRAP_CTRL_IRQ_EN
    logic            irq_timer_i;
    logic            mstatus_mie_i;
`endif
    logic            csr_trap_o;
    logic            csr_mret_o;
    logic [XLEN-1:0] csr_mepc_o;
    logic [XLEN-1:0] csr_mcause_o;
    logic            stall_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [XLEN-1:0] trap_cnt_o;

    modport slave (
        input  wb_valid_i, wb_pc_i, exc_ecall_i, exc_illegal_i, exc_mret_i,
        input  mtvec_i, mepc_i, redirect_ready_i,
`ifdef TRAP_CTRL_IRQ_EN
        input  irq_timer_i, mstatus_mie_i,
`endif
        output csr_trap_o, csr_mret_o, csr_mepc_o, csr_mcause_o,
        output stall_o, redirect_valid_o, redirect_pc_o, trap_cnt_o
    );

    modport master (
        output wb_valid_i, wb_pc_i, exc_ecall_i, exc_illegal_i, exc_mret_i,
        output mtvec_i, mepc_i, redirect_ready_i,
`ifdef TRAP_CTRL_IRQ_EN
        output irq_timer_i, mstatus_mie_i,
`endif
        input  csr_trap_o, csr_mret_o, csr_mepc_o, csr_mcause_o,
        input  stall_o, redirect_valid_o, redirect_pc_o, trap_cnt_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/mret sequencer: CSR strobes then IFU redirect (timer irq with TRAP_CTRL_IRQ_EN)
module trap_ctrl #(
    parameter int XLEN        = 32,
    parameter int CAUSE_ECALL = 11,
    parameter int CAUSE_ILL   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    trap_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SAVE, REDIR} state_t;

    state_t          state_q, state_nx;
    logic [XLEN-1:0] mepc_q, mcause_q, cnt_q;
    logic            is_mret_q;

    logic            ev_ill, ev_ecall, ev_mret, ev_irq, ev_trap;
    logic [XLEN-1:0] ev_mepc, ev_cause;

    assign ev_ill   = bus.wb_valid_i & bus.exc_illegal_i;
    assign ev_ecall = bus.wb_valid_i & bus.exc_ecall_i & ~bus.exc_illegal_i;
    assign ev_mret  = bus.wb_valid_i & bus.exc_mret_i & ~bus.exc_illegal_i & ~bus.exc_ecall_i;
`ifdef TRAP_CTRL_IRQ_EN
    assign ev_irq   = bus.wb_valid_i & bus.irq_timer_i & bus.mstatus_mie_i
                    & ~bus.exc_illegal_i & ~bus.exc_ecall_i & ~bus.exc_mret_i;
`else
    assign ev_irq   = 1'b0;
`endif
    assign ev_trap  = ev_ill | ev_ecall | ev_irq;

    // Interrupt resumes after the retiring instruction, exceptions re-point at it.
    always_comb begin
        ev_mepc  = bus.wb_pc_i;
        ev_cause = XLEN'(CAUSE_ECALL);
        if (ev_ill) begin
            ev_cause = XLEN'(CAUSE_ILL);
        end else if (ev_irq) begin
            ev_mepc  = bus.wb_pc_i + XLEN'(4);
            ev_cause = {1'b1, (XLEN-1)'(7)};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mepc_q    <= '0;
            mcause_q  <= '0;
            cnt_q     <= '0;
            is_mret_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            if (state_q == IDLE && (ev_trap || ev_mret)) begin
                is_mret_q <= ev_mret;
            end
            if (state_q == IDLE && ev_trap) begin
                mepc_q   <= ev_mepc;
                mcause_q <= ev_cause;
            end
            if (state_q == SAVE && !is_mret_q) begin
                cnt_q <= cnt_q + XLEN'(1);
            end
        end
    end

    always_comb begin
        state_nx             = state_q;
        bus.csr_trap_o       = 1'b0;
        bus.csr_mret_o       = 1'b0;
        bus.redirect_valid_o = 1'b0;
        bus.redirect_pc_o    = '0;
        unique case (state_q)
            IDLE: begin
                if (ev_trap || ev_mret) state_nx = SAVE;
            end
            SAVE: begin
                bus.csr_trap_o = ~is_mret_q;
                bus.csr_mret_o = is_mret_q;
                state_nx       = REDIR;
            end
            REDIR: begin
                // CSRs already reflect the SAVE-cycle update, so targets are taken live.
                bus.redirect_valid_o = 1'b1;
                bus.redirect_pc_o    = is_mret_q ? bus.mepc_i : (bus.mtvec_i & ~XLEN'(3));
                if (bus.redirect_ready_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.stall_o      = (state_q != IDLE);
    assign bus.csr_mepc_o   = mepc_q;
    assign bus.csr_mcause_o = mcause_q;
    assign bus.trap_cnt_o   = cnt_q;
endmodule
